// File: rtl/numf_display_drv.sv
// Shows an 8-bit frequency index in decimal on a 4-digit multiplexed 7-segment display.
// A free-running double-dabble converter feeds display registers that update atomically.
module numf_display_drv #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       CLKNEXYS,
    input  logic       MRst,
    input  logic       En,
    input  logic [7:0] numF_i,
    output logic [6:0] seg_o,
    output logic [3:0] an_o,
    output logic       dp_o
);

    localparam int unsigned CntW = $clog2(REFRESH_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {StLoad, StShift, StUpdate} state_e;

    state_e          state_q;
    logic [7:0]      shift_q;
    logic [11:0]     bcd_q;
    logic [2:0]      bit_cnt_q;
    logic [3:0]      disp_h_q, disp_t_q, disp_u_q;
    logic [CntW-1:0] refresh_q;
    logic [1:0]      idx_q;

    logic [11:0]     bcd_adj;
    logic [19:0]     dabble;
    logic [11:0]     disp_nxt;
    logic [1:0]      idx_nxt;
    logic            refresh_tc;
    logic [3:0]      an_d;
    logic [6:0]      seg_d;

    function automatic logic [11:0] add3(input logic [11:0] b);
        logic [11:0] r;
        for (int i = 0; i < 3; i++) begin
            r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
        end
        return r;
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        bcd_adj = add3(bcd_q);
        dabble  = {bcd_adj, shift_q} << 1;
    end

    always_ff @(posedge CLKNEXYS or negedge MRst) begin
        if (!MRst) begin
            state_q   <= StLoad;
            shift_q   <= '0;
            bcd_q     <= '0;
            bit_cnt_q <= '0;
            disp_h_q  <= '0;
            disp_t_q  <= '0;
            disp_u_q  <= '0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    shift_q   <= numF_i;
                    bcd_q     <= '0;
                    bit_cnt_q <= '0;
                    state_q   <= StShift;
                end
                StShift: begin
                    bcd_q     <= dabble[19:8];
                    shift_q   <= dabble[7:0];
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_q <= StUpdate;
                end
                StUpdate: begin
                    disp_h_q <= bcd_q[11:8];
                    disp_t_q <= bcd_q[7:4];
                    disp_u_q <= bcd_q[3:0];
                    state_q  <= StLoad;
                end
                default: state_q <= StLoad;
            endcase
        end
    end

    assign refresh_tc = (refresh_q == CntMax);

    always_ff @(posedge CLKNEXYS or negedge MRst) begin
        if (!MRst) begin
            refresh_q <= '0;
            idx_q     <= '0;
        end else begin
            refresh_q <= refresh_tc ? '0 : refresh_q + 1'b1;
            idx_q     <= idx_nxt;
        end
    end

    // Outputs are built from next-state values so anode and segments track idx/disp exactly.
    always_comb begin
        disp_nxt = (state_q == StUpdate) ? bcd_q : {disp_h_q, disp_t_q, disp_u_q};
        idx_nxt  = refresh_tc ? idx_q + 2'd1 : idx_q;
        an_d     = 4'b1111;
        seg_d    = 7'h7F;
        if (En) begin
            case (idx_nxt)
                2'd0: begin
                    an_d  = 4'b1110;
                    seg_d = decode(disp_nxt[3:0]);
                end
                2'd1: begin
                    if (disp_nxt[11:4] != 8'd0) begin
                        an_d  = 4'b1101;
                        seg_d = decode(disp_nxt[7:4]);
                    end
                end
                2'd2: begin
                    if (disp_nxt[11:8] != 4'd0) begin
                        an_d  = 4'b1011;
                        seg_d = decode(disp_nxt[11:8]);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLKNEXYS or negedge MRst) begin
        if (!MRst) begin
            an_o  <= 4'b1111;
            seg_o <= 7'h7F;
        end else begin
            an_o  <= an_d;
            seg_o <= seg_d;
        end
    end

    assign dp_o = 1'b1;

endmodule

// File: tb/tb_numf_display_drv.sv
// Randomized bench for numf_display_drv: a cycle-count model of conversion and scan is
// compared against the DUT every cycle, with literal digit patterns pinning the model.
module tb_numf_display_drv;

    localparam int unsigned R = 4;

    logic       CLKNEXYS;
    logic       MRst;
    logic       En;
    logic [7:0] numF_i;
    logic [6:0] seg_o;
    logic [3:0] an_o;
    logic       dp_o;

    int errors = 0;
    int checks = 0;
    bit check_en = 0;

    numf_display_drv #(.REFRESH_DIV(R)) dut (
        .CLKNEXYS (CLKNEXYS),
        .MRst     (MRst),
        .En       (En),
        .numF_i   (numF_i),
        .seg_o    (seg_o),
        .an_o     (an_o),
        .dp_o     (dp_o)
    );

    initial begin
        CLKNEXYS = 1'b0;
        forever #5 CLKNEXYS = ~CLKNEXYS;
    end

    logic [6:0] dec_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Model: k_m counts clock edges since reset release. A value is sampled every 10th edge
    // and appears on the display 9 edges later; the slot advances every R edges.
    int k_m = 0;
    int latch_m = 0;
    int disp_m = 0;
    bit en_m = 0;

    always @(posedge CLKNEXYS or negedge MRst) begin
        if (!MRst) begin
            k_m     <= 0;
            latch_m <= 0;
            disp_m  <= 0;
            en_m    <= 0;
        end else begin
            if (k_m % 10 == 0) latch_m <= int'(numF_i);
            if (k_m % 10 == 9) disp_m <= latch_m;
            en_m <= En;
            k_m  <= k_m + 1;
        end
    end

    function automatic void model_out(output logic [3:0] a, output logic [6:0] s);
        int h, t, u, idx;
        a = 4'b1111;
        s = 7'h7F;
        if (k_m != 0 && en_m) begin
            h   = disp_m / 100;
            t   = (disp_m / 10) % 10;
            u   = disp_m % 10;
            idx = (k_m / R) % 4;
            if (idx == 0) begin
                a = 4'b1110; s = dec_tbl[u];
            end else if (idx == 1 && (h != 0 || t != 0)) begin
                a = 4'b1101; s = dec_tbl[t];
            end else if (idx == 2 && h != 0) begin
                a = 4'b1011; s = dec_tbl[h];
            end
        end
    endfunction

    always @(negedge CLKNEXYS) begin
        logic [3:0] a;
        logic [6:0] s;
        if (check_en) begin
            model_out(a, s);
            checks++;
            if (an_o !== a || seg_o !== s) begin
                errors++;
                $display("FAIL model t=%0t: an_o=%b seg_o=%b expected an_o=%b seg_o=%b",
                         $time, an_o, seg_o, a, s);
            end
            checks++;
            if (dp_o !== 1'b1 || $countones(~an_o) > 1) begin
                errors++;
                $display("FAIL dp_anodes t=%0t: dp_o=%b an_o=%b expected dp_o=1 one anode",
                         $time, dp_o, an_o);
            end
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLKNEXYS);
            #1;
        end
    endtask

    task automatic wait_an(input logic [3:0] a, input logic [6:0] s, input string name);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge CLKNEXYS);
            #1;
            if (an_o === a) found = 1;
        end
        checks++;
        if (!found || seg_o !== s) begin
            errors++;
            $display("FAIL %s: an_o=%b seg_o=%b expected an_o=%b seg_o=%b",
                     name, an_o, seg_o, a, s);
        end
    endtask

    task automatic never_an(input logic [3:0] a, input int n, input string name);
        bit seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLKNEXYS);
            #1;
            if (an_o === a) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL %s: an_o=%b was driven, expected never", name, a);
        end
    endtask

    task automatic check_reset_vals(input string name);
        checks++;
        if (an_o !== 4'b1111 || seg_o !== 7'h7F || dp_o !== 1'b1) begin
            errors++;
            $display("FAIL %s: an_o=%b seg_o=%b dp_o=%b expected 1111 1111111 1",
                     name, an_o, seg_o, dp_o);
        end
    endtask

    initial begin
        MRst   = 1'b1;
        En     = 1'b1;
        numF_i = 8'd0;
        #2 MRst = 1'b0;
        #1 check_reset_vals("reset");
        check_en = 1;
        #19 MRst = 1'b1;

        // 255: all three digits lit
        cycles(1);
        numF_i = 8'd255;
        cycles(25);
        wait_an(4'b1110, 7'b0010010, "t1_units");
        wait_an(4'b1101, 7'b0010010, "t1_tens");
        wait_an(4'b1011, 7'b0100100, "t1_hund");
        wait_an(4'b1111, 7'b1111111, "t1_slot3");

        // 7: tens and hundreds blanked
        numF_i = 8'd7;
        cycles(25);
        wait_an(4'b1110, 7'b1111000, "t2_units");
        never_an(4'b1101, 20, "t2_tens_blank");
        never_an(4'b1011, 1, "t2_hund_blank");

        // 100: embedded zeros shown
        numF_i = 8'd100;
        cycles(25);
        wait_an(4'b1011, 7'b1111001, "t3_hund");
        wait_an(4'b1101, 7'b1000000, "t3_tens");
        wait_an(4'b1110, 7'b1000000, "t3_units");

        // 42 -> short 43 glitch -> 43
        numF_i = 8'd42;
        cycles(25);
        cycles(3);
        numF_i = 8'd43;
        cycles(2);
        numF_i = 8'd42;
        cycles(3);
        numF_i = 8'd43;
        cycles(20);
        wait_an(4'b1110, 7'b0110000, "t4_units");
        wait_an(4'b1101, 7'b0011001, "t4_tens");

        // asynchronous reset pulse mid-scan
        @(posedge CLKNEXYS);
        #2 MRst = 1'b0;
        #1 check_reset_vals("t5_async_reset");
        #9 MRst = 1'b1;
        cycles(11);
        wait_an(4'b1110, 7'b0110000, "t5_units_after");

        // enable off then on with 99
        En     = 1'b0;
        numF_i = 8'd99;
        never_an(4'b1110, 25, "t6_off_units");
        never_an(4'b1101, 1, "t6_off_tens");
        En = 1'b1;
        wait_an(4'b1110, 7'b0010000, "t6_units");
        wait_an(4'b1101, 7'b0010000, "t6_tens");
        never_an(4'b1011, 20, "t6_hund_blank");

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            @(negedge CLKNEXYS);
            #1;
            if ($urandom_range(7) == 0) numF_i = 8'($urandom);
            if ($urandom_range(15) == 0) En = ~En;
        end
        En = 1'b1;
        cycles(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
